// File: rtl/condicionador_botoes.sv
// ---------------------------------------------------------------------------
// condicionador_botoes
// Conditions the raw button pins for the LED-matrix puzzle controller.
// Each channel goes through polarity fix, a 2-flop synchroniser, a
// counter-based debounce and a rising-edge one-shot, so that every physical
// press yields exactly one 1-cycle pulse. It also keeps a saturating count
// of the moves played.
//
// Optional feature: define BOTOES_SERIALIZA_EN to queue simultaneous rise
// events in a pending register and issue at most one pulse per cycle. The
// lowest-index channel wins.
//
// Parameters
//   N_BOTOES        number of button channels
//   DEBOUNCE_CYCLES consecutive mismatching clocks before the level flips (>=2)
//   ACTIVE_LOW      1: raw low means pressed
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   enable          1: pulses allowed; 0: pulses suppressed, tracking goes on
//   clr_jogadas     synchronous clear of jogadas (wins over that edge's pulses)
//   botoes_raw      raw asynchronous button pins
//   botoes_pulso    registered 1-cycle press pulses
//   botoes_estavel  debounced level, 1 = pressed
//   jogadas         moves counter, saturates at 255
// ---------------------------------------------------------------------------
module condicionador_botoes #(
    parameter int N_BOTOES        = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clr_jogadas,
    input  logic [N_BOTOES-1:0] botoes_raw,
    output logic [N_BOTOES-1:0] botoes_pulso,
    output logic [N_BOTOES-1:0] botoes_estavel,
    output logic [7:0]          jogadas
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PC_W  = $clog2(N_BOTOES + 1);
    localparam int SUM_W = ((PC_W > 8) ? PC_W : 8) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BOTOES-1:0]            p;
    logic [N_BOTOES-1:0]            s1_q, s2_q;
    logic [N_BOTOES-1:0]            estavel_q, estavel_d;
    logic [N_BOTOES-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_BOTOES-1:0]            pulso_q, pulso_d;
    logic [N_BOTOES-1:0]            rise;
    logic [7:0]                     jogadas_q, jogadas_d;
    logic [PC_W-1:0]                n_pulsos;
    logic [SUM_W-1:0]               soma;

    // Inversion happens ahead of the synchroniser so everything downstream
    // sees 1 = pressed.
    assign p = (ACTIVE_LOW != 0) ? ~botoes_raw : botoes_raw;

    // Debounce: count consecutive samples that disagree with the stable level;
    // any agreeing sample restarts the count.
    always_comb begin
        for (int i = 0; i < N_BOTOES; i++) begin
            cnt_d[i]     = '0;
            estavel_d[i] = estavel_q[i];
            if (s2_q[i] != estavel_q[i]) begin
                if (cnt_q[i] == CNT_LAST) estavel_d[i] = s2_q[i];
                else                      cnt_d[i]     = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Rise event is the edge where the stable level goes 0->1, so the pulse
    // flop rises on the same edge as estavel.
    assign rise = estavel_d & ~estavel_q;

`ifdef BOTOES_SERIALIZA_EN
    logic [N_BOTOES-1:0] pending_q, pending_d;
    logic [N_BOTOES-1:0] cand, grant;

    always_comb begin
        cand  = pending_q | rise;      // re-rise on a pending channel merges
        grant = cand & (~cand + N_BOTOES'(1)); // isolate lowest set bit
        if (enable) begin
            pulso_d   = grant;
            pending_d = cand & ~grant;
        end else begin
            pulso_d   = '0;
            pending_d = '0;            // disabled: queued events are dropped
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end
`else
    // Events while disabled are dropped, never deferred.
    assign pulso_d = enable ? rise : '0;
`endif

    // Moves counter: add the pulses issued on this edge, saturate at 255.
    always_comb begin
        n_pulsos = '0;
        for (int i = 0; i < N_BOTOES; i++) n_pulsos = n_pulsos + PC_W'(pulso_d[i]);
        soma = SUM_W'(jogadas_q) + SUM_W'(n_pulsos);
        if (clr_jogadas)              jogadas_d = 8'd0;
        else if (soma > SUM_W'(255))  jogadas_d = 8'hFF;
        else                          jogadas_d = soma[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            estavel_q <= '0;
            pulso_q   <= '0;
            jogadas_q <= '0;
        end else begin
            s1_q      <= p;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            estavel_q <= estavel_d;
            pulso_q   <= pulso_d;
            jogadas_q <= jogadas_d;
        end
    end

    assign botoes_pulso   = pulso_q;
    assign botoes_estavel = estavel_q;
    assign jogadas        = jogadas_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
module tb_condicionador_botoes;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       clr_jogadas = 1'b0;
    logic [7:0] botoes_raw = 8'h00;
    logic [7:0] botoes_pulso, botoes_estavel, jogadas;

    int n_vec = 0;
    int n_err = 0;

    condicionador_botoes #(.N_BOTOES(8), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_jogadas(clr_jogadas),
        .botoes_raw(botoes_raw), .botoes_pulso(botoes_pulso),
        .botoes_estavel(botoes_estavel), .jogadas(jogadas)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] raw;
        logic       en;
        logic       clr;
        logic [7:0] exp_pulso;
        logic [7:0] exp_estavel;
        logic [7:0] exp_jogadas;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic [7:0] raw, input logic en, input logic clr,
                       input logic [7:0] ep, input logic [7:0] ee, input logic [7:0] ej);
        vec_t v;
        v.raw = raw; v.en = en; v.clr = clr;
        v.exp_pulso = ep; v.exp_estavel = ee; v.exp_jogadas = ej;
        tab.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Drive inputs, clock one edge, land 1 time unit after it for sampling.
    task automatic step(input logic [7:0] raw, input logic en, input logic clr);
        botoes_raw = raw; enable = en; clr_jogadas = clr;
        @(posedge clk);
        #1;
    endtask

    int cnt, idx, fall;

    initial begin
        // ---- reset state
        #2;
        chk("reset_pulso", botoes_pulso, 0);
        chk("reset_estavel", botoes_estavel, 0);
        chk("reset_jogadas", jogadas, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ---- table: clean press/release on bit 3, then simultaneous 0x81
        for (int k = 1; k <= 10; k++)
            add(8'h08, 1, 0, (k == 6) ? 8'h08 : 8'h00, (k >= 6) ? 8'h08 : 8'h00, (k >= 6) ? 8'd1 : 8'd0);
        for (int k = 1; k <= 8; k++)
            add(8'h00, 1, 0, 8'h00, (k < 6) ? 8'h08 : 8'h00, 8'd1);
        add(8'h00, 1, 1, 8'h00, 8'h00, 8'd0);
        for (int k = 1; k <= 9; k++) begin
`ifdef BOTOES_SERIALIZA_EN
            add(8'h81, 1, 0, (k == 6) ? 8'h01 : (k == 7) ? 8'h80 : 8'h00,
                (k >= 6) ? 8'h81 : 8'h00, (k == 6) ? 8'd1 : (k >= 7) ? 8'd2 : 8'd0);
`else
            add(8'h81, 1, 0, (k == 6) ? 8'h81 : 8'h00,
                (k >= 6) ? 8'h81 : 8'h00, (k >= 6) ? 8'd2 : 8'd0);
`endif
        end
        for (int k = 1; k <= 8; k++)
            add(8'h00, 1, 0, 8'h00, (k < 6) ? 8'h81 : 8'h00, 8'd2);
        add(8'h00, 1, 1, 8'h00, 8'h00, 8'd0);

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].raw, tab[i].en, tab[i].clr);
            chk($sformatf("tab%0d_pulso", i), botoes_pulso, tab[i].exp_pulso);
            chk($sformatf("tab%0d_estavel", i), botoes_estavel, tab[i].exp_estavel);
            chk($sformatf("tab%0d_jogadas", i), jogadas, tab[i].exp_jogadas);
        end

        // ---- bounce on bit 0: 1,0,1,0 then steady high; last rise before edge 5
        cnt = 0; idx = -1;
        for (int k = 1; k <= 25; k++) begin
            step((k == 2 || k == 4) ? 8'h00 : 8'h01, 1, 0);
            if (botoes_pulso[0]) begin cnt++; if (idx < 0) idx = k; end
        end
        chk("bounce_npulse", cnt, 1);
        chk("bounce_edge", idx, 10);
        chk("bounce_jogadas", jogadas, 1);
        repeat (10) step(8'h00, 1, 0);
        step(8'h00, 1, 1);

        // ---- hold bit 5 for 100 cycles, release, re-press
        cnt = 0; fall = -1;
        for (int k = 1; k <= 100; k++) begin
            step(8'h20, 1, 0);
            if (botoes_pulso[5]) cnt++;
        end
        for (int k = 1; k <= 20; k++) begin
            step(8'h00, 1, 0);
            if (botoes_pulso[5]) cnt++;
            if (!botoes_estavel[5] && fall < 0) fall = k;
        end
        chk("hold_release_fall", fall, 6);
        for (int k = 1; k <= 20; k++) begin
            step(8'h20, 1, 0);
            if (botoes_pulso[5]) cnt++;
        end
        for (int k = 1; k <= 10; k++) begin
            step(8'h00, 1, 0);
            if (botoes_pulso[5]) cnt++;
        end
        chk("hold_npulse", cnt, 2);
        chk("hold_jogadas", jogadas, 2);
        step(8'h00, 1, 1);

        // ---- enable=0 through the rise, then re-enabled while still held
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step(8'h02, (k > 12), 0);
            if (botoes_pulso != 8'h00) cnt++;
        end
        chk("enable_estavel", botoes_estavel, 8'h02);
        for (int k = 1; k <= 10; k++) begin
            step(8'h00, 1, 0);
            if (botoes_pulso != 8'h00) cnt++;
        end
        chk("enable_npulse", cnt, 0);
        chk("enable_jogadas", jogadas, 0);

        // ---- saturation: 300 presses on bit 2
        for (int n = 0; n < 300; n++) begin
            repeat (8) step(8'h04, 1, 0);
            repeat (8) step(8'h00, 1, 0);
            if (n == 9) chk("sat_jogadas_10", jogadas, 10);
        end
        chk("sat_jogadas", jogadas, 255);

        // ---- async reset while bit 0 is 2 cycles into debounce
        for (int k = 1; k <= 4; k++) step(8'h01, 1, 0);
        #2 rst = 1'b1; botoes_raw = 8'h00;
        #1;
        chk("rst_async_jogadas", jogadas, 0);
        chk("rst_async_estavel", botoes_estavel, 0);
        chk("rst_async_pulso", botoes_pulso, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step(8'h00, 1, 0);
            if (botoes_pulso != 8'h00 || botoes_estavel != 8'h00) cnt++;
        end
        chk("rst_no_pulse", cnt, 0);

        // ---- clr_jogadas on the pulse edge: clear wins, pulse not counted
        for (int k = 1; k <= 10; k++) step(8'h10, 1, 0);
        chk("pre_clr_jogadas", jogadas, 1);
        repeat (8) step(8'h00, 1, 0);
        for (int k = 1; k <= 6; k++) step(8'h10, 1, (k == 6));
        chk("clr_prio_pulso", botoes_pulso, 8'h10);
        chk("clr_prio_jogadas", jogadas, 0);
        step(8'h10, 1, 0);
        chk("clr_after_jogadas", jogadas, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
